// File: rtl/proc_bypass_scoreboard.sv
// Hazard/bypass scoreboard: tracks destination registers of in-flight instructions in
// S post-decode slots and produces per-source bypass selects plus a decode stall.
module proc_bypass_scoreboard #(
  parameter int p_nstages    = 3,
  parameter int p_nsrcs      = 2,
  parameter int p_addr_nbits = 5,
  localparam int c_sel_nbits = $clog2(p_nstages + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_nstages-1:0]              adv,
  input  logic                              issue_val,
  input  logic                              issue_wen,
  input  logic [p_addr_nbits-1:0]           issue_waddr,
  input  logic [c_sel_nbits-1:0]            issue_avail,
  input  logic                              issue_var,
  input  logic                              x_result_val,
  input  logic                              squash_X,
  input  logic [p_nsrcs-1:0]                src_val,
  input  logic [p_nsrcs*p_addr_nbits-1:0]   src_addr,
  output logic [p_nsrcs*c_sel_nbits-1:0]    bypass_sel,
  output logic                              stall_D,
  output logic [c_sel_nbits-1:0]            inflight
);

  typedef struct packed {
    logic                    val;
    logic                    wen;
    logic [p_addr_nbits-1:0] waddr;
    logic [c_sel_nbits-1:0]  avail;
    logic                    is_var;
  } entry_t;

  // Array index k holds slot k+1 (index 0 = X, index p_nstages-1 = W).
  entry_t slots     [p_nstages];
  entry_t slots_nxt [p_nstages];
  entry_t head;
  logic [c_sel_nbits-1:0] issue_avail_eff;

  // Controller contract: stall_D is advisory; while it is high the controller keeps
  // issue_val=0 or adv[0]=0, and adv only ever stalls from slot 1 upward.
  assign issue_avail_eff = (issue_avail == '0 || issue_avail > c_sel_nbits'(p_nstages))
                           ? c_sel_nbits'(p_nstages) : issue_avail;

  always_comb begin
    head = slots[0];
    if (squash_X) head.val = 1'b0;
    for (int k = 0; k < p_nstages; k++) slots_nxt[k] = slots[k];
    slots_nxt[0] = head;
    if (adv[0]) begin
      slots_nxt[0].val    = issue_val;
      slots_nxt[0].wen    = issue_wen;
      slots_nxt[0].waddr  = issue_waddr;
      slots_nxt[0].avail  = issue_avail_eff;
      slots_nxt[0].is_var = issue_var;
    end
    for (int k = 1; k < p_nstages; k++) begin
      if (adv[k]) begin
        if (!adv[k-1])  slots_nxt[k] = '0;
        else if (k == 1) slots_nxt[k] = head;
        else             slots_nxt[k] = slots[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < p_nstages; k++) slots[k] <= '0;
    end else begin
      for (int k = 0; k < p_nstages; k++) slots[k] <= slots_nxt[k];
    end
  end

  // Youngest match wins: scan oldest to youngest so the lowest slot overwrites.
  always_comb begin
    logic [p_addr_nbits-1:0] addr;
    logic [c_sel_nbits-1:0]  sel;
    logic                    hit;
    logic                    rdy;
    bypass_sel = '0;
    stall_D    = 1'b0;
    for (int i = 0; i < p_nsrcs; i++) begin
      addr = src_addr[i*p_addr_nbits +: p_addr_nbits];
      sel  = '0;
      hit  = 1'b0;
      rdy  = 1'b0;
      for (int k = p_nstages - 1; k >= 0; k--) begin
        if (slots[k].val && slots[k].wen && slots[k].waddr == addr) begin
          hit = 1'b1;
          sel = c_sel_nbits'(k + 1);
          rdy = (c_sel_nbits'(k + 1) >= slots[k].avail) &&
                (!(slots[k].is_var && k == 0) || x_result_val);
        end
      end
      if (src_val[i] && addr != '0 && hit) begin
        bypass_sel[i*c_sel_nbits +: c_sel_nbits] = sel;
        stall_D = stall_D | !rdy;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < p_nstages; k++) begin
      if (slots[k].val && slots[k].wen && slots[k].waddr != '0)
        inflight = inflight + c_sel_nbits'(1);
    end
  end

  generate
    if (p_nstages > 1) begin : g_mono_chk
      logic adv_bad;
      assign adv_bad = |(~adv[p_nstages-1:1] & adv[p_nstages-2:0]);
      a_adv_monotonic: assert property (@(posedge clk) disable iff (!reset) !adv_bad);
    end
  endgenerate

  a_avail_legal: assert property (@(posedge clk) disable iff (!reset)
    !(issue_val && adv[0]) || (issue_avail != '0 && issue_avail <= c_sel_nbits'(p_nstages)));

endmodule

// File: tb/tb_proc_bypass_scoreboard.sv
// Self-checking bench for proc_bypass_scoreboard: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a slot model.
module tb_proc_bypass_scoreboard;

  localparam int S  = 3;
  localparam int NS = 2;
  localparam int A  = 5;
  localparam int SW = $clog2(S + 1);

  logic              clk;
  logic              reset;
  logic [S-1:0]      adv;
  logic              issue_val;
  logic              issue_wen;
  logic [A-1:0]      issue_waddr;
  logic [SW-1:0]     issue_avail;
  logic              issue_var;
  logic              x_result_val;
  logic              squash_X;
  logic [NS-1:0]     src_val;
  logic [NS*A-1:0]   src_addr;
  logic [NS*SW-1:0]  bypass_sel;
  logic              stall_D;
  logic [SW-1:0]     inflight;

  int checks   = 0;
  int failures = 0;

  proc_bypass_scoreboard #(.p_nstages(S), .p_nsrcs(NS), .p_addr_nbits(A)) dut (
    .clk(clk), .reset(reset), .adv(adv), .issue_val(issue_val), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .issue_avail(issue_avail), .issue_var(issue_var),
    .x_result_val(x_result_val), .squash_X(squash_X), .src_val(src_val),
    .src_addr(src_addr), .bypass_sel(bypass_sel), .stall_D(stall_D), .inflight(inflight)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit val;
    bit wen;
    int waddr;
    int avail;
    bit is_var;
  } ment_t;

  ment_t m [1:S];

  task automatic model_clear();
    for (int k = 1; k <= S; k++) m[k] = '{0, 0, 0, 0, 0};
  endtask

  task automatic model_step();
    ment_t prev [1:S];
    int av;
    for (int k = 1; k <= S; k++) prev[k] = m[k];
    if (squash_X) prev[1].val = 0;
    av = int'(issue_avail);
    if (av == 0 || av > S) av = S;
    for (int k = 1; k <= S; k++) begin
      if (!adv[k-1])       m[k] = prev[k];
      else if (k == 1)     m[1] = '{issue_val, issue_wen, int'(issue_waddr), av, issue_var};
      else if (adv[k-2])   m[k] = prev[k-1];
      else                 m[k] = '{0, 0, 0, 0, 0};
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_clear();
    else        model_step();
  end

  task automatic model_lookup(input bit used, input int addr, output int sel, output bit stl);
    bit found;
    sel = 0;
    stl = 0;
    found = 0;
    if (used && addr != 0) begin
      for (int k = 1; k <= S; k++) begin
        if (!found && m[k].val && m[k].wen && m[k].waddr == addr) begin
          found = 1;
          sel = k;
          stl = !(k >= m[k].avail && (!(m[k].is_var && k == 1) || x_result_val));
        end
      end
    end
  endtask

  function automatic int model_inflight();
    int n = 0;
    for (int k = 1; k <= S; k++)
      if (m[k].val && m[k].wen && m[k].waddr != 0) n++;
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int  s;
    bit  st;
    bit  any;
    any = 0;
    for (int i = 0; i < NS; i++) begin
      model_lookup(src_val[i], int'(src_addr[i*A +: A]), s, st);
      chk($sformatf("cmp_sel%0d", i), 32'(bypass_sel[i*SW +: SW]), 32'(s));
      any = any | st;
    end
    chk("cmp_stall_D", 32'(stall_D), 32'(any));
    chk("cmp_inflight", 32'(inflight), 32'(model_inflight()));
  end

  // ---------------- driver tasks ----------------
  function automatic int sel_of(input int i);
    return int'(bypass_sel[i*SW +: SW]);
  endfunction

  task automatic idle();
    adv          = '1;
    issue_val    = 1'b0;
    issue_wen    = 1'b0;
    issue_waddr  = '0;
    issue_avail  = SW'(1);
    issue_var    = 1'b0;
    x_result_val = 1'b0;
    squash_X     = 1'b0;
    src_val      = '0;
    src_addr     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    issue_val = 1'b0;
    squash_X  = 1'b0;
  endtask

  task automatic flush();
    idle();
    repeat (S + 1) tick();
  endtask

  task automatic issue(input bit wen, input int waddr, input int avail, input bit is_var);
    issue_val   = 1'b1;
    issue_wen   = wen;
    issue_waddr = A'(waddr);
    issue_avail = SW'(avail);
    issue_var   = is_var;
  endtask

  task automatic look(input int i, input int addr);
    src_val[i] = 1'b1;
    src_addr[i*A +: A] = A'(addr);
  endtask

  task automatic expect_now(input string nm, input int i, input int sel, input bit stl, input int infl);
    #1;
    chk({nm, "_sel"}, 32'(sel_of(i)), 32'(sel));
    chk({nm, "_stall"}, 32'(stall_D), 32'(stl));
    chk({nm, "_inflight"}, 32'(inflight), 32'(infl));
  endtask

  task automatic rand_cycle();
    int n;
    n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S) : 0;
    adv          = S'((1 << S) - (1 << n));
    issue_val    = 1'($urandom_range(0, 1));
    issue_wen    = ($urandom_range(0, 3) != 0);
    issue_waddr  = A'($urandom_range(0, 7));
    issue_avail  = SW'($urandom_range(1, S));
    issue_var    = ($urandom_range(0, 3) == 0);
    x_result_val = 1'($urandom_range(0, 1));
    squash_X     = ($urandom_range(0, 7) == 0);
    for (int i = 0; i < NS; i++) begin
      src_val[i] = ($urandom_range(0, 3) != 0);
      src_addr[i*A +: A] = A'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    idle();
    #3;
    chk("reset_sel0", 32'(sel_of(0)), 32'd0);
    chk("reset_stall", 32'(stall_D), 32'd0);
    chk("reset_inflight", 32'(inflight), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();

    // back-to-back ALU bypass walking X -> M -> W -> regfile
    issue(1, 5, 1, 0);
    tick();
    look(0, 5);
    expect_now("alu_x", 0, 1, 0, 1);
    tick(); expect_now("alu_m", 0, 2, 0, 1);
    tick(); expect_now("alu_w", 0, 3, 0, 1);
    tick(); expect_now("alu_rf", 0, 0, 0, 0);

    // load-use: stall in X, resolved from M after a bubble enters X
    flush();
    issue(1, 6, 2, 0);
    tick();
    look(1, 6);
    expect_now("lu_x", 1, 1, 1, 1);
    tick();
    expect_now("lu_m", 1, 2, 0, 1);

    // youngest match wins, x0 never bypassed or counted
    flush();
    issue(1, 7, 1, 0); tick();
    issue(1, 7, 1, 0); tick();
    look(0, 7);
    expect_now("young", 0, 1, 0, 2);
    idle();
    issue(1, 0, 1, 0); tick();
    look(0, 0);
    expect_now("x0", 0, 0, 0, 2);

    // variable latency held in X
    flush();
    issue(1, 9, 1, 1); tick();
    adv = S'(3'b110);
    look(0, 9);
    for (int c = 0; c < 4; c++) begin
      expect_now($sformatf("var_wait%0d", c), 0, 1, 1, 1);
      if (c < 3) tick();
    end
    x_result_val = 1'b1;
    expect_now("var_done", 0, 1, 0, 1);

    // squash of the held multiply, alone and with a simultaneous issue
    x_result_val = 1'b0;
    adv = '1;
    squash_X = 1'b1;
    tick();
    expect_now("squash", 0, 0, 0, 0);
    issue(1, 9, 1, 1); tick();
    adv = S'(3'b110); tick();
    adv = '1;
    squash_X = 1'b1;
    issue(1, 10, 1, 0);
    tick();
    look(1, 10);
    expect_now("sq_old", 0, 0, 0, 1);
    #1 chk("sq_new_sel", 32'(sel_of(1)), 32'd1);

    // asynchronous reset between edges
    flush();
    issue(1, 1, 1, 0); tick();
    issue(1, 2, 1, 0); tick();
    issue(1, 3, 1, 0); tick();
    look(0, 1);
    look(1, 3);
    expect_now("pre_rst", 0, 3, 0, 3);
    #1 reset = 1'b0;
    expect_now("async_rst0", 0, 0, 0, 0);
    #0 chk("async_rst1_sel", 32'(sel_of(1)), 32'd0);
    #1 reset = 1'b1;
    idle();
    issue(1, 5, 1, 0); tick();
    look(0, 5);
    expect_now("post_rst", 0, 1, 0, 1);

    // randomized traffic, checked by the compare process every cycle
    flush();
    for (int c = 0; c < 400; c++) rand_cycle();
    idle();
    repeat (2) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
